// File: rtl/time_set_ctrl.sv
// Time-of-day counter with a three-state key-driven set mode.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_RUN       | time advances on sec_tick, key_inc ignored, blink held at 0
//   ST_SET_HOUR  | time frozen, key_inc steps hour, sec_tick toggles blink
//   ST_SET_MIN   | time frozen, key_inc steps minute, sec_tick toggles blink
//
// Leaving ST_SET_MIN zeroes the seconds, so the new time starts on a whole
// minute. All outputs come straight from registers.
module time_set_ctrl #(
    parameter int HOURS = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] mode,
    output logic       blink,
    output logic       rollover
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    localparam logic [4:0] HOUR_MAX = 5'(HOURS - 1);
    localparam logic [5:0] MS_MAX   = 6'd59;

    state_t     state_q, state_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] minute_q, minute_d;
    logic [5:0] second_q, second_d;
    logic       blink_q, blink_d;
    logic       rollover_q, rollover_d;

    logic       sec_at_max;
    logic       min_at_max;
    logic       hour_at_max;
    logic [4:0] hour_inc;
    logic [5:0] minute_inc;
    logic [5:0] second_inc;

    // Compare-to-max then load zero; counters never pass through an illegal value.
    assign sec_at_max  = (second_q == MS_MAX);
    assign min_at_max  = (minute_q == MS_MAX);
    assign hour_at_max = (hour_q == HOUR_MAX);
    assign hour_inc    = hour_at_max ? 5'd0 : hour_q + 5'd1;
    assign minute_inc  = min_at_max  ? 6'd0 : minute_q + 6'd1;
    assign second_inc  = sec_at_max  ? 6'd0 : second_q + 6'd1;

    // State register and time fields; synchronous reset overrides every input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            hour_q     <= 5'd0;
            minute_q   <= 6'd0;
            second_q   <= 6'd0;
            blink_q    <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            minute_q   <= minute_d;
            second_q   <= second_d;
            blink_q    <= blink_d;
            rollover_q <= rollover_d;
        end
    end

    // Next-state, time update and blink/rollover generation.
    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        blink_d    = blink_q;
        rollover_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                blink_d = 1'b0;
                // A tick coincident with key_mode still lands, carries included.
                if (sec_tick) begin
                    second_d = second_inc;
                    if (sec_at_max) begin
                        minute_d = minute_inc;
                        if (min_at_max) begin
                            hour_d     = hour_inc;
                            rollover_d = hour_at_max;
                        end
                    end
                end
                if (key_mode) begin
                    state_d = ST_SET_HOUR;
                end
            end

            ST_SET_HOUR: begin
                if (key_mode) begin
                    state_d = ST_SET_MIN;
                    blink_d = 1'b0;
                end else begin
                    if (key_inc) begin
                        hour_d = hour_inc;
                    end
                    if (sec_tick) begin
                        blink_d = ~blink_q;
                    end
                end
            end

            ST_SET_MIN: begin
                if (key_mode) begin
                    state_d  = ST_RUN;
                    blink_d  = 1'b0;
                    second_d = 6'd0;
                end else begin
                    if (key_inc) begin
                        minute_d = minute_inc;
                    end
                    if (sec_tick) begin
                        blink_d = ~blink_q;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    assign hour     = hour_q;
    assign minute   = minute_q;
    assign second   = second_q;
    assign mode     = state_q;
    assign blink    = blink_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a 24-hour and a 12-hour instance driven by the same
// keys, each checked against a seconds-of-day reference model via a scoreboard.
module tb_time_set_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset    = 1'b1;
    logic sec_tick = 1'b0;
    logic key_mode = 1'b0;
    logic key_inc  = 1'b0;

    logic [4:0] hour_a, hour_b;
    logic [5:0] minute_a, minute_b;
    logic [5:0] second_a, second_b;
    logic [1:0] mode_a, mode_b;
    logic       blink_a, blink_b;
    logic       roll_a, roll_b;

    time_set_ctrl #(.HOURS(24)) dut_24 (
        .clock(clock), .reset(reset), .sec_tick(sec_tick),
        .key_mode(key_mode), .key_inc(key_inc),
        .hour(hour_a), .minute(minute_a), .second(second_a),
        .mode(mode_a), .blink(blink_a), .rollover(roll_a)
    );

    time_set_ctrl #(.HOURS(12)) dut_12 (
        .clock(clock), .reset(reset), .sec_tick(sec_tick),
        .key_mode(key_mode), .key_inc(key_inc),
        .hour(hour_b), .minute(minute_b), .second(second_b),
        .mode(mode_b), .blink(blink_b), .rollover(roll_b)
    );

    typedef struct {
        int h0, m0, s0, r0;
        int h1, m1, s1, r1;
        int md, bl;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: time kept as seconds of the day, mode as 0/1/2.
    int t_day [2];
    int roll_m[2];
    int mode_m;
    int blink_m;
    int hmod  [2] = '{24, 12};

    task automatic check(input string name, input logic [31:0] act, input int req);
        total++;
        if (act !== 32'(req)) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_step(input bit rst, input bit km, input bit ki, input bit st);
        int h, m, s;
        if (rst) begin
            t_day   = '{0, 0};
            roll_m  = '{0, 0};
            mode_m  = 0;
            blink_m = 0;
            return;
        end
        roll_m = '{0, 0};
        for (int k = 0; k < 2; k++) begin
            h = t_day[k] / 3600;
            m = (t_day[k] / 60) % 60;
            s = t_day[k] % 60;
            case (mode_m)
                0: if (st) begin
                    t_day[k] = t_day[k] + 1;
                    if (t_day[k] == hmod[k] * 3600) begin
                        t_day[k]  = 0;
                        roll_m[k] = 1;
                    end
                end
                1: if (!km && ki) t_day[k] = ((h + 1) % hmod[k]) * 3600 + m * 60 + s;
                default: begin
                    if (km)      t_day[k] = h * 3600 + m * 60;
                    else if (ki) t_day[k] = h * 3600 + ((m + 1) % 60) * 60 + s;
                end
            endcase
        end
        if (km) begin
            mode_m  = (mode_m + 1) % 3;
            blink_m = 0;
        end else if (mode_m != 0 && st) begin
            blink_m = 1 - blink_m;
        end
    endfunction

    task automatic step(input bit rst, input bit km, input bit ki, input bit st);
        exp_t e;
        @(negedge clock);
        reset    = rst;
        key_mode = km;
        key_inc  = ki;
        sec_tick = st;
        model_step(rst, km, ki, st);
        e.h0 = t_day[0] / 3600; e.m0 = (t_day[0] / 60) % 60; e.s0 = t_day[0] % 60; e.r0 = roll_m[0];
        e.h1 = t_day[1] / 3600; e.m1 = (t_day[1] / 60) % 60; e.s1 = t_day[1] % 60; e.r1 = roll_m[1];
        e.md = mode_m;
        e.bl = blink_m;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge produces one registered output set to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("hour24",   32'(hour_a),   e.h0);
                check("minute24", 32'(minute_a), e.m0);
                check("second24", 32'(second_a), e.s0);
                check("roll24",   32'(roll_a),   e.r0);
                check("mode24",   32'(mode_a),   e.md);
                check("blink24",  32'(blink_a),  e.bl);
                check("hour12",   32'(hour_b),   e.h1);
                check("minute12", 32'(minute_b), e.m1);
                check("second12", 32'(second_b), e.s1);
                check("roll12",   32'(roll_b),   e.r1);
                check("mode12",   32'(mode_b),   e.md);
                check("blink12",  32'(blink_b),  e.bl);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        step(0, 0, 0, 0);

        // 3661 ticks from reset: 01:01:01, no rollover
        for (int i = 0; i < 3661; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // preload HOURS-1:59:59 through set mode, then wrap the day
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 23; i++) step(0, 0, 1, i % 3 == 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 1, i % 2 == 0);
        step(0, 1, 0, 1);
        for (int i = 0; i < 59; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // hour and minute wrap in set mode without carrying
        step(0, 1, 0, 0);
        for (int i = 0; i < 24; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 60; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);

        // SET_MIN with second 37: key_mode + sec_tick returns to RUN at second 0
        for (int i = 0; i < 37; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);

        // key_mode beats key_inc in SET_HOUR
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);

        // reset mid-edit discards edits, then a tick gives second 1
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0);
        end

        @(negedge clock);
        reset    = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        sec_tick = 1'b0;
        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter HOURS, default 24, SHALL set the hour modulus; legal values are 12 and 24, and the hour range is 0..HOURS-1.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 sec_tick  input  1  SHALL be a one-cycle pulse, once per second.
REQ-005 key_mode  input  1  SHALL be a one-cycle debounced press pulse from the mode key stage.
REQ-006 key_inc  input  1  SHALL be a one-cycle debounced press pulse from the increment key stage.
REQ-007 hour  output  5  SHALL be the current hour, binary.
REQ-008 minute  output  6  SHALL be the current minute, binary.
REQ-009 second  output  6  SHALL be the current second, binary.
REQ-010 mode  output  2  SHALL encode state: 0=RUN, 1=SET_HOUR, 2=SET_MIN; 3 is never driven.
REQ-011 blink  output  1  SHALL be the display blink-phase flag for the field being edited.
REQ-012 rollover  output  1  SHALL be a one-cycle pulse on the day wrap.

Function
REQ-013 All outputs SHALL be registered; each input event SHALL be visible on the outputs one cycle after the edge that samples it.
REQ-014 FSM transitions on key_mode SHALL be RUN->SET_HOUR->SET_MIN->RUN; key_mode SHALL be ignored when absent and never skip a state.
REQ-015 In RUN, sec_tick SHALL advance second 0..59, with wrap 59->0.
REQ-016 A second wrap SHALL advance minute 0..59; a minute wrap SHALL advance hour 0..HOURS-1.
REQ-017 Wrap HOURS-1:59:59 -> 00:00:00 SHALL assert rollover for exactly one cycle, together with the new time.
REQ-018 In SET_HOUR and SET_MIN, sec_tick SHALL NOT advance time.
REQ-019 In SET_HOUR, key_inc SHALL increment hour modulo HOURS, with no carry into or out of other fields.
REQ-020 In SET_MIN, key_inc SHALL increment minute modulo 60, with no carry into hour.
REQ-021 In RUN, key_inc SHALL be ignored.
REQ-022 key_mode and key_inc in the same cycle: key_mode SHALL win and key_inc SHALL be discarded.
REQ-023 key_mode and sec_tick in the same cycle in RUN: the tick SHALL be applied (carries included) and the state SHALL move to SET_HOUR.
REQ-024 The SET_MIN->RUN transition SHALL clear second to 0 in the same update, overriding any coincident sec_tick.
REQ-025 blink SHALL be 0 in RUN.
REQ-026 In SET states, blink SHALL toggle on each sec_tick and SHALL be cleared to 0 on every state transition.
REQ-027 Counters SHALL never hold out-of-range values; every increment SHALL be a compare-to-max then load-zero, never a binary overflow.
REQ-028 rollover SHALL never assert outside RUN.

Reset
REQ-029 While reset=1 at a clock edge, the state SHALL become RUN and hour, minute, second, blink and rollover SHALL become 0; mode SHALL read 0.
REQ-030 Reset SHALL take priority over all simultaneous inputs, including mid-edit; no edited value SHALL survive reset.
REQ-031 Inputs SHALL be ignored in the cycle reset is asserted; normal operation SHALL resume on the first edge with reset=0.

Verification
REQ-032 Reset, then 3661 sec_tick pulses in RUN -> 01:01:01, rollover never asserted.
REQ-033 Preload 23:59:59 via set mode and ticks, then one sec_tick -> 00:00:00 and rollover high for exactly one cycle; with HOURS=12, 11:59:59 -> 00:00:00.
REQ-034 In SET_HOUR at hour 23, press key_inc -> hour 0 and minute unchanged; in SET_MIN at minute 59, press key_inc -> minute 0 and hour unchanged.
REQ-035 In SET_MIN with second=37, assert key_mode and sec_tick in the same cycle -> mode 0, second 0, blink 0.
REQ-036 In SET_HOUR, assert key_mode and key_inc together -> mode 2, hour unchanged.
REQ-037 In SET_MIN after two key_inc pulses, assert reset -> all outputs 0 and mode 0 on the next cycle; then a sec_tick -> second 1.
